// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked, registered ALU execution stage.
// Logic/arithmetic ops complete in one cycle. Shifts run on a 1-bit-per-cycle
// serial shifter unless ALU_BARREL_SHIFT_EN is defined, in which case a
// single-cycle barrel shifter is used and the unit never stalls.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-low reset
//   valid_i         request; accepted on an edge where valid_i && ready_o
//   ALU_Operation_i 4-bit opcode from ALU control
//   A_i, B_i        operands (shift amount = B_i[SHAMT_WIDTH-1:0])
//   ready_o         unit can accept a request this cycle (state decode only)
//   valid_o         one-cycle completion pulse
//   result_o        registered result, held until the next completion
//   zero_o          registered (result_o == 0), updated with result_o
module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_LUI = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  single_res;

    assign shamt  = B_i[SHAMT_WIDTH-1:0];
    assign accept = valid_i && ready_o;

    // Single-cycle result; for serial shifts this is only used when shamt == 0.
    always_comb begin
        single_res = '0;
        case (ALU_Operation_i)
            OP_ADD: single_res = A_i + B_i;
            OP_SUB: single_res = A_i - B_i;
            OP_OR:  single_res = A_i | B_i;
            OP_AND: single_res = A_i & B_i;
            OP_XOR: single_res = A_i ^ B_i;
            OP_LUI: single_res = B_i;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: single_res = A_i << shamt;
            OP_SRL: single_res = A_i >> shamt;
`else
            OP_SLL: single_res = A_i;
            OP_SRL: single_res = A_i;
`endif
            default: single_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    assign ready_o = 1'b1;

    // Every op completes on its accept edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_o <= '0;
            zero_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= accept;
            if (accept) begin
                result_o <= single_res;
                zero_o   <= (single_res == '0);
            end
        end
    end

`else

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [SHAMT_WIDTH-1:0] count_q, count_d;
    logic                   dir_right_q, dir_right_d;
    logic [DATA_WIDTH-1:0]  result_d;
    logic                   zero_d;
    logic                   valid_d;
    logic [DATA_WIDTH-1:0]  shifted;

    assign ready_o = (state_q == IDLE);
    assign shifted = dir_right_q ? (work_q >> 1) : (work_q << 1);

    // State and datapath register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            dir_right_q <= 1'b0;
            result_o    <= '0;
            zero_o      <= 1'b0;
            valid_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            dir_right_q <= dir_right_d;
            result_o    <= result_d;
            zero_o      <= zero_d;
            valid_o     <= valid_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        count_d     = count_q;
        dir_right_d = dir_right_q;
        result_d    = result_o;
        zero_d      = zero_o;
        valid_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((ALU_Operation_i == OP_SLL || ALU_Operation_i == OP_SRL)
                        && shamt != '0) begin
                        work_d      = A_i;
                        dir_right_d = (ALU_Operation_i == OP_SRL);
                        count_d     = shamt;
                        state_d     = SHIFT;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d  = shifted;
                count_d = count_q - SHAMT_WIDTH'(1);
                // Last step: publish the shifted value directly.
                if (count_q == SHAMT_WIDTH'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`endif

endmodule
